// File: rtl/mouse_packetizer.sv
// Mouse report packetizer.
// Accumulates signed per-cycle motion into saturating 9-bit counters and
// latches click requests. On each report_tick it snapshots that state and,
// when there is something to report, emits a 3-byte packet over a
// valid/ready byte stream.
module mouse_packetizer #(
  parameter int SEND_EMPTY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dx,
  input  logic [7:0] dy,
  input  logic       left_click_pulse,
  input  logic       right_click_pulse,
  input  logic       report_tick,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_B0,
    S_B1,
    S_B2
  } state_t;

  localparam logic signed [9:0] ACC_MAX = 10'sd255;
  localparam logic signed [9:0] ACC_MIN = -10'sd256;

  state_t     state_q, state_d;
  logic [8:0] acc_x_q, acc_x_d;
  logic [8:0] acc_y_q, acc_y_d;
  logic       ovf_x_q, ovf_x_d;
  logic       ovf_y_q, ovf_y_d;
  logic       pend_l_q, pend_l_d;
  logic       pend_r_q, pend_r_d;
  logic [1:0] last_btn_q, last_btn_d;
  logic [7:0] byte1_q, byte1_d;
  logic [7:0] byte2_q, byte2_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;

  logic [9:0] step_x, step_y;
  logic       take_snap;
  logic       send_pkt;

  // Add one cycle of motion to an accumulator at 10 bits and saturate to
  // the 9-bit signed range; the MSB of the result flags that a clamp occurred.
  function automatic logic [9:0] acc_step(input logic [8:0] acc, input logic [7:0] d);
    logic signed [9:0] sum;
    sum = $signed({acc[8], acc}) + $signed({{2{d[7]}}, d});
    if (sum > ACC_MAX) begin
      return {1'b1, 9'h0FF};
    end else if (sum < ACC_MIN) begin
      return {1'b1, 9'h100};
    end else begin
      return {1'b0, sum[8:0]};
    end
  endfunction

  assign step_x    = acc_step(acc_x_q, dx);
  assign step_y    = acc_step(acc_y_q, dy);
  assign take_snap = (state_q == S_IDLE) && report_tick;
  // A report is worth sending if anything moved, saturated, was clicked, or
  // the previous packet showed a button held (so the release gets reported).
  assign send_pkt  = (SEND_EMPTY != 0) || (acc_x_q != 9'd0) || (acc_y_q != 9'd0) ||
                     ovf_x_q || ovf_y_q || pend_l_q || pend_r_q || (last_btn_q != 2'b00);

  // Next-state: accumulation, snapshot on tick, and byte sequencing.
  always_comb begin
    state_d    = state_q;
    acc_x_d    = step_x[8:0];
    acc_y_d    = step_y[8:0];
    ovf_x_d    = ovf_x_q | step_x[9];
    ovf_y_d    = ovf_y_q | step_y[9];
    pend_l_d   = pend_l_q | left_click_pulse;
    pend_r_d   = pend_r_q | right_click_pulse;
    last_btn_d = last_btn_q;
    byte1_d    = byte1_q;
    byte2_d    = byte2_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    case (state_q)
      S_IDLE: begin
        if (take_snap) begin
          // This cycle's motion and clicks start the next report window.
          acc_x_d  = {dx[7], dx};
          acc_y_d  = {dy[7], dy};
          ovf_x_d  = 1'b0;
          ovf_y_d  = 1'b0;
          pend_l_d = left_click_pulse;
          pend_r_d = right_click_pulse;
          if (send_pkt) begin
            state_d    = S_B0;
            tx_valid_d = 1'b1;
            tx_data_d  = {ovf_y_q, ovf_x_q, acc_y_q[8], acc_x_q[8],
                          1'b1, 1'b0, pend_r_q, pend_l_q};
            byte1_d    = acc_x_q[7:0];
            byte2_d    = acc_y_q[7:0];
            last_btn_d = {pend_r_q, pend_l_q};
          end
        end
      end
      S_B0: begin
        if (tx_ready) begin
          state_d   = S_B1;
          tx_data_d = byte1_q;
        end
      end
      S_B1: begin
        if (tx_ready) begin
          state_d   = S_B2;
          tx_data_d = byte2_q;
        end
      end
      S_B2: begin
        if (tx_ready) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase
  end

  // State registers; reset abandons any packet in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_x_q    <= 9'd0;
      acc_y_q    <= 9'd0;
      ovf_x_q    <= 1'b0;
      ovf_y_q    <= 1'b0;
      pend_l_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      last_btn_q <= 2'b00;
      byte1_q    <= 8'h00;
      byte2_q    <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      ovf_x_q    <= ovf_x_d;
      ovf_y_q    <= ovf_y_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      last_btn_q <= last_btn_d;
      byte1_q    <= byte1_d;
      byte2_q    <= byte2_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mouse_packetizer.sv
// Scoreboard bench for mouse_packetizer: stimulus pushes expected bytes,
// a negedge monitor pops and compares each accepted byte.
module tb_mouse_packetizer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dx, dy;
  logic       left_click_pulse, right_click_pulse, report_tick, tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, busy;

  typedef struct {
    logic [7:0] data;
    int         cyc;   // expected cycle of presentation, -1 = not timed
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  mouse_packetizer #(.SEND_EMPTY(0)) dut (
    .clk               (clk),
    .rst               (rst),
    .dx                (dx),
    .dy                (dy),
    .left_click_pulse  (left_click_pulse),
    .right_click_pulse (right_click_pulse),
    .report_tick       (report_tick),
    .tx_ready          (tx_ready),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: every accepted byte must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && tx_valid && tx_ready) begin
        n_cmp = n_cmp + 1;
        if (exp_q.size() == 0) begin
          n_bad = n_bad + 1;
          $display("FAIL unexpected_byte: got %02h at cycle %0d expected none", tx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
            n_bad = n_bad + 1;
            $display("FAIL byte: got %02h at cycle %0d expected %02h at cycle %0d",
                     tx_data, cyc, e.data, e.cyc);
          end else begin
            $display("byte %02h at cycle %0d ok", tx_data, cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp = n_cmp + 1;
    if (got !== want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %02h expected %02h", name, got, want);
    end else begin
      $display("%s: %02h ok", name, got);
    end
  endtask

  // One cycle of inputs, then return to quiet inputs #1 after the edge.
  task automatic drive(input logic [7:0] x, input logic [7:0] y,
                       input logic l, input logic r, input logic t);
    dx = x; dy = y; left_click_pulse = l; right_click_pulse = r; report_tick = t;
    @(posedge clk);
    #1;
    dx = 8'h00; dy = 8'h00; left_click_pulse = 1'b0; right_click_pulse = 1'b0;
    report_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Queue a packet whose first byte appears the cycle after the upcoming tick.
  task automatic expect_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input bit timed);
    exp_t e;
    e.data = b0; e.cyc = cyc + 1;                exp_q.push_back(e);
    e.data = b1; e.cyc = timed ? cyc + 2 : -1;  exp_q.push_back(e);
    e.data = b2; e.cyc = timed ? cyc + 3 : -1;  exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; tx_ready = 1'b1;
    dx = 8'h00; dy = 8'h00; left_click_pulse = 1'b0; right_click_pulse = 1'b0;
    report_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_valid", {7'd0, tx_valid}, 8'h00);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;
    idle(2);

    // Steady motion, reported with exact latency.
    for (int i = 0; i < 10; i++) drive(8'd3, 8'hFE, 1'b0, 1'b0, 1'b0);
    expect_pkt(8'h28, 8'h1E, 8'hEC, 1'b1);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Saturation sets ovfX; the following empty tick sends nothing.
    for (int i = 0; i < 5; i++) drive(8'd100, 8'h00, 1'b0, 1'b0, 1'b0);
    expect_pkt(8'h48, 8'hFF, 8'h00, 1'b1);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(5);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Left click: pressed once, released once, then silence.
    drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(2);
    expect_pkt(8'h09, 8'h00, 8'h00, 1'b1);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(5);
    expect_pkt(8'h08, 8'h00, 8'h00, 1'b1);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(5);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Backpressure on byte1, ignored tick and motion during the send.
    drive(8'd2, 8'h00, 1'b0, 1'b0, 1'b0);
    expect_pkt(8'h08, 8'h02, 8'h00, 1'b0);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(8'd1, 8'h00, 1'b0, 1'b0, 1'b0);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_data", tx_data, 8'h02);
      check("stall_valid", {7'd0, tx_valid}, 8'h01);
      drive(8'd1, 8'h00, 1'b0, 1'b0, (i == 2));
    end
    check("stall_data_end", tx_data, 8'h02);
    check("stall_busy_end", {7'd0, busy}, 8'h01);
    tx_ready = 1'b1;
    drive(8'd1, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(8'd1, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(4);
    expect_pkt(8'h08, 8'h08, 8'h00, 1'b1);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Right click coincident with tick lands in the next packet.
    drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    idle(3);
    expect_pkt(8'h0A, 8'h00, 8'h00, 1'b1);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(5);
    expect_pkt(8'h08, 8'h00, 8'h00, 1'b1);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Asynchronous reset while byte1 is on the bus.
    drive(8'd5, 8'h00, 1'b0, 1'b0, 1'b0);
    e.data = 8'h08; e.cyc = cyc + 1; exp_q.push_back(e);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    drive(8'd7, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    check("b1_busy", {7'd0, busy}, 8'h01);
    rst = 1'b1;
    #1;
    check("async_rst_valid", {7'd0, tx_valid}, 8'h00);
    check("async_rst_busy", {7'd0, busy}, 8'h00);
    check("async_rst_data", tx_data, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(6);

    check("scoreboard_empty", exp_q.size() > 255 ? 8'hFF : 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
